// File: rtl/facto_calc_if.sv
// Request/bank-write bundle between a factorial requester and facto_calc_seq.
// The master drives the request; the slave (the engine) drives the bank writes.
interface facto_calc_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             clear;
  logic [WIDTH-1:0] operand;
  logic [6:0]       wr_en;
  logic [WIDTH:0]   wr_data;
  logic             busy;
  logic             done;

  modport master (
    output start, clear, operand,
    input  wr_en, wr_data, busy, done
  );

  modport slave (
    input  start, clear, operand,
    output wr_en, wr_data, busy, done
  );
endinterface

// File: rtl/facto_calc_seq.sv
// Sequential factorial engine and register-bank write sequencer.
// Computes N! with one shift-add multiply (WIDTH steps) per factor, then
// writes operand, status, result and a 4-deep result history into a
// 7-slot bank, one slot per cycle. Overflow aborts the remaining multiplies.
module facto_calc_seq #(
  parameter int WIDTH     = 64,
  parameter int HIST_BASE = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  facto_calc_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    IDLE,
    W_OPND,
    W_STAT_BUSY,
    INIT,
    MUL,
    NEXT,
    W_RES,
    W_HIST,
    W_STAT_DONE,
    W_CLR
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]   i_reg;        // holds N from start until INIT, then the next factor
  logic [WIDTH-1:0]   mplier_reg;   // multiplier, consumed LSB first
  logic [2*WIDTH-1:0] mcand_reg;    // multiplicand, shifted left each step
  logic [2*WIDTH-1:0] prod_reg;
  logic [SW-1:0]      step_reg;
  logic               ovf_reg;
  logic [1:0]         hist_ptr_reg;

  logic [WIDTH-1:0]   i_dec;
  logic               ovf_calc;
  logic               last_step;
  logic [WIDTH:0]     status_busy;
  logic [WIDTH:0]     status_done;
  logic [WIDTH:0]     result_word;
  logic [6:0]         hist_onehot;

  logic [6:0]         wr_en_comb;
  logic [WIDTH:0]     wr_data_comb;
  logic               busy_comb;
  logic               done_comb;

  assign i_dec     = i_reg - WIDTH'(1);
  // Overflow is sticky: once a product spills into the upper half it stays set.
  assign ovf_calc  = ovf_reg | (|prod_reg[2*WIDTH-1:WIDTH]);
  assign last_step = (step_reg == SW'(WIDTH - 1));

  // Status word: bit0 busy, bit1 done, bit2 ovf, bits[4:3] history pointer.
  assign status_busy = (WIDTH+1)'({hist_ptr_reg, ovf_reg, 2'b01});
  assign status_done = (WIDTH+1)'({hist_ptr_reg, ovf_reg, 2'b10});
  assign result_word = ovf_reg ? {1'b1, {WIDTH{1'b0}}} : {1'b0, acc_reg};

  // One-hot select of the history slot addressed by the history pointer.
  for (genvar gi = 0; gi < 7; gi++) begin : g_hist_sel
    if (gi >= HIST_BASE && gi < HIST_BASE + 4) begin : g_slot
      assign hist_onehot[gi] = (hist_ptr_reg == 2'(gi - HIST_BASE));
    end else begin : g_none
      assign hist_onehot[gi] = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and Moore output decode; clear overrides everything.
  always_comb begin
    state_next   = state_reg;
    wr_en_comb   = '0;
    wr_data_comb = '0;
    busy_comb    = 1'b1;
    done_comb    = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_comb = 1'b0;
        if (bus.start) state_next = W_OPND;
      end
      W_OPND: begin
        wr_en_comb   = 7'b000_0001;
        wr_data_comb = {1'b0, i_reg};
        state_next   = W_STAT_BUSY;
      end
      W_STAT_BUSY: begin
        wr_en_comb   = 7'b000_0010;
        wr_data_comb = status_busy;
        state_next   = INIT;
      end
      INIT: begin
        state_next = (i_reg < WIDTH'(2)) ? W_RES : MUL;
      end
      MUL: begin
        if (last_step) state_next = NEXT;
      end
      NEXT: begin
        state_next = (ovf_calc || (i_dec < WIDTH'(2))) ? W_RES : MUL;
      end
      W_RES: begin
        wr_en_comb   = 7'b000_0100;
        wr_data_comb = result_word;
        state_next   = W_HIST;
      end
      W_HIST: begin
        wr_en_comb   = hist_onehot;
        wr_data_comb = result_word;
        state_next   = W_STAT_DONE;
      end
      W_STAT_DONE: begin
        wr_en_comb   = 7'b000_0010;
        wr_data_comb = status_done;
        busy_comb    = 1'b0;
        done_comb    = 1'b1;
        state_next   = IDLE;
      end
      W_CLR: begin
        wr_en_comb   = 7'b000_0010;
        wr_data_comb = '0;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (bus.clear) state_next = W_CLR;
  end

  assign bus.wr_en   = wr_en_comb;
  assign bus.wr_data = wr_data_comb;
  assign bus.busy    = busy_comb;
  assign bus.done    = done_comb;

  // Datapath: operand capture, shift-add multiply, overflow and history pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg      <= WIDTH'(1);
      i_reg        <= '0;
      mplier_reg   <= '0;
      mcand_reg    <= '0;
      prod_reg     <= '0;
      step_reg     <= '0;
      ovf_reg      <= 1'b0;
      hist_ptr_reg <= '0;
    end else if (bus.clear) begin
      ovf_reg      <= 1'b0;
      hist_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) i_reg <= bus.operand;
        end
        INIT: begin
          // First multiply is 1 * N; i already holds N.
          acc_reg    <= WIDTH'(1);
          ovf_reg    <= 1'b0;
          mcand_reg  <= (2*WIDTH)'(1);
          mplier_reg <= i_reg;
          prod_reg   <= '0;
          step_reg   <= '0;
        end
        MUL: begin
          if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          step_reg   <= step_reg + SW'(1);
        end
        NEXT: begin
          // Commit the product and set up acc * (i-1) for a possible next pass.
          acc_reg    <= prod_reg[WIDTH-1:0];
          ovf_reg    <= ovf_calc;
          i_reg      <= i_dec;
          mcand_reg  <= {{WIDTH{1'b0}}, prod_reg[WIDTH-1:0]};
          mplier_reg <= i_dec;
          prod_reg   <= '0;
          step_reg   <= '0;
        end
        W_HIST: begin
          hist_ptr_reg <= hist_ptr_reg + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
